registers_tx_block: RTL and testbench
=====================================

// Module: registers_tx_block
// PURPOSE
//  Transmit-side counterpart of registers_rx_block: host register readback.
//  - Snoops the shared register bus (addr/data/rdy) and keeps a shadow copy of registers 0..NUM_REGS-1.
//  - On rqst_regs, emits a framed dump through one tx_protocol source port (data/rdy/eof/ack), alongside chA/chB/trigger status.
// PARAMETERS
//  REG_ADDR_WIDTH  8     register bus address width
//  REG_DATA_WIDTH  16    register width; fixed at 16 (two bytes per register)
//  TX_DATA_WIDTH   8     tx_protocol byte width
//  NUM_REGS        16    shadowed registers, addresses 0..NUM_REGS-1; 1..255
//  DEFAULTS        0     packed NUM_REGS*REG_DATA_WIDTH reset values; reg i at [i*16 +: 16]
//  FRAME_HEADER    8'hA5 first byte of every dump frame
// PORTS
//  clk            in   1   system clock (clk_100M domain)
//  rst            in   1   asynchronous active-low reset
//  register_addr  in   REG_ADDR_WIDTH  register bus address
//  register_data  in   REG_DATA_WIDTH  register bus data
//  register_rdy   in   1   one-cycle write strobe on register bus
//  rqst_regs      in   1   one-cycle dump request from rx block
//  tx_data        out  TX_DATA_WIDTH   byte to tx_protocol
//  tx_rdy         out  1   tx_data/tx_eof valid
//  tx_eof         out  1   current byte is last of frame
//  tx_ack         in   1   tx_protocol accepts the current byte
//  busy           out  1   dump in progress or pending
// BEHAVIOUR
//  Reset (rst=0, async): tx_rdy=0, tx_eof=0, tx_data=0, busy=0, FSM=IDLE, pending=0, checksum=0, shadow[i]=DEFAULTS[i].
//  Shadow: on register_rdy && register_addr<NUM_REGS, shadow[addr]<=register_data next edge. Other addresses are ignored.
//  Frame: HEADER, NUM_REGS, then per i ascending {i, data[7:0], data[15:8]}, then CHK.
//   - CHK = XOR of all prior frame bytes. Length = 3+3*NUM_REGS (51 at default).
//  Handshake: tx_data/tx_eof stable while tx_rdy=1. Byte transfers on an edge with tx_rdy&&tx_ack.
//   - Next byte is presented the following cycle with tx_rdy held high, so there are no idle gaps.
//   - tx_ack while tx_rdy=0 is ignored. tx_eof=1 only on CHK.
//  FSM: IDLE -> HDR -> CNT -> ADDR -> DL -> DH -> (ADDR if i<NUM_REGS-1, else CHK) -> IDLE.
//   - Each state advances only on transfer.
//   - Latency: rqst_regs in IDLE -> tx_rdy=1 with HEADER on the next cycle.
//   - CHK transfer -> tx_rdy=0 the next cycle, unless pending is set.
//  Coherency: shadow[i] is latched into a 16-bit word register when ADDR(i) is loaded. A write to reg i during its DL/DH does not tear the pair.
//  Simultaneous register_rdy and load of the same index: the latched word takes the NEW data (write forwarded).
//  rqst_regs while busy: sets pending (depth 1; extra requests coalesce). After CHK transfer, go to HDR directly with tx_rdy held high.
//  busy = (FSM!=IDLE)||pending.
//  Reset mid-frame: frame is abandoned, no eof is emitted, tx_rdy drops immediately; tx_protocol is reset by the same rst.
//  Widths: the index counter is 8 bits and compares against NUM_REGS-1 (no wrap). Checksum is an 8-bit XOR, cleared on entering HDR.
// STRUCTURE
//  Shared package/defines (conf_regs_defines.v): FRAME_HEADER value, `__NUM_READBACK_REGS, FSM state encodings.
//  One natural sub-module: reg_shadow_file (NUM_REGS x 16 write port, one async read port plus forwarding); the FSM stays in this module.
// TESTING
//  1 Reset, no writes, rqst_regs, tx_ack=1 always
//    -> 51 bytes A5,10,00,00,00,01,00,00..., eof only on byte 51; CHK = A5^10^(XOR of indices 0..15) = B5.
//  2 Write reg3=16'hBEEF, reg20=16'h1234, then dump
//    -> bytes 03,EF,BE present; reg20 absent; CHK updated accordingly.
//  3 tx_ack random ~30% duty
//    -> byte sequence identical to case 1; data/eof never change while tx_rdy=1 without ack.
//  4 rqst_regs x3 during a frame
//    -> exactly two frames back-to-back, tx_rdy never low between them; busy falls after 2nd eof.
//  5 Write reg5 on the cycle ADDR(5) loads, and again during DL(5)
//    -> frame carries the first new value; the second appears only in the next dump.
//  6 rst low mid-DH of reg7
//    -> tx_rdy=0 asynchronously, shadow=DEFAULTS; the next rqst_regs yields a clean full frame.

Source files
------------

// File: rtl/registers_tx_block_pkg.sv
// Shared constants and FSM encoding for the register readback transmitter.
// Holds the default frame header, default register count and dump-frame states.
// No logic and no ports; imported by the top and the shadow file.
package registers_tx_block_pkg;

  localparam logic [7:0] FRAME_HEADER_DEF  = 8'hA5;
  localparam int         NUM_READBACK_REGS = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_ADDR = 3'd3,
    ST_DL   = 3'd4,
    ST_DH   = 3'd5,
    ST_CHK  = 3'd6
  } tx_state_e;

endpackage

// File: rtl/registers_tx_block_shadow.sv
// Shadow copy of registers 0..NUM_REGS-1, snooped from the shared register bus.
// Write lands on the next edge; the read port is combinational and forwards a same-cycle write.
// No backpressure: every in-range write strobe is accepted.
// Ports: clk/rst, wr_en_i/wr_addr_i/wr_data_i (bus snoop), rd_idx_i -> rd_data_o.
module registers_tx_block_shadow
  import registers_tx_block_pkg::*;
#(
  parameter int                       AW       = 8,
  parameter int                       NUM_REGS = NUM_READBACK_REGS,
  parameter logic [NUM_REGS*16-1:0]   DEFAULTS = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [15:0]   wr_data_i,
  input  logic [7:0]    rd_idx_i,
  output logic [15:0]   rd_data_o
);

  logic [15:0] mem_q [NUM_REGS];
  logic        wr_hit;

  // Out-of-range addresses belong to other register blocks and are ignored.
  assign wr_hit = wr_en_i && (int'(wr_addr_i) < NUM_REGS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= DEFAULTS[i*16 +: 16];
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit && (int'(wr_addr_i) == i)) mem_q[i] <= wr_data_i;
      end
    end
  end

  // A write to the word being latched on the same edge must win, so forward it.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_idx_i) == i) rd_data_o = mem_q[i];
    end
    if (wr_hit && (int'(wr_addr_i) == int'(rd_idx_i))) rd_data_o = wr_data_i;
  end

endmodule

// File: rtl/registers_tx_block.sv
// Register readback transmitter: on rqst_regs, sends HDR, COUNT, {idx,lo,hi}*N, XOR checksum.
// Latency: HEADER is presented the cycle after rqst_regs in idle; back-to-back bytes with no gaps.
// Backpressure: tx_data/tx_eof hold while tx_rdy is high until tx_ack; one extra request is queued.
// Ports: clk/rst, register_addr/data/rdy (bus snoop), rqst_regs, tx_data/tx_rdy/tx_eof/tx_ack, busy.
module registers_tx_block
  import registers_tx_block_pkg::*;
#(
  parameter int                     REG_ADDR_WIDTH = 8,
  parameter int                     REG_DATA_WIDTH = 16,
  parameter int                     TX_DATA_WIDTH  = 8,
  parameter int                     NUM_REGS       = NUM_READBACK_REGS,
  parameter logic [NUM_REGS*16-1:0] DEFAULTS       = '0,
  parameter logic [7:0]             FRAME_HEADER   = FRAME_HEADER_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  input  logic                      rqst_regs,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);
  localparam logic [7:0] NUM_BYTE = 8'(NUM_REGS);

  tx_state_e   state_q;
  logic [7:0]  idx_q;
  logic [15:0] word_q;
  logic [7:0]  chk_q;
  logic        pending_q;
  logic [7:0]  tx_data_q;
  logic        tx_rdy_q;
  logic        tx_eof_q;

  logic        xfer;
  logic [7:0]  chk_nxt;
  logic [7:0]  rd_idx;
  logic [15:0] rd_data;

  assign xfer    = tx_rdy_q && tx_ack;
  assign chk_nxt = chk_q ^ tx_data_q;
  // Index of the word latched when the next ADDR byte is loaded.
  assign rd_idx  = (state_q == ST_CNT) ? 8'd0 : idx_q + 8'd1;

  registers_tx_block_shadow #(
    .AW       (REG_ADDR_WIDTH),
    .NUM_REGS (NUM_REGS),
    .DEFAULTS (DEFAULTS)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (register_rdy),
    .wr_addr_i (register_addr),
    .wr_data_i (register_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      pending_q <= 1'b0;
      tx_data_q <= '0;
      tx_rdy_q  <= 1'b0;
      tx_eof_q  <= 1'b0;
    end else begin
      // Requests during a frame coalesce into one pending dump; cleared below when consumed.
      if ((state_q != ST_IDLE) && rqst_regs) pending_q <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (rqst_regs) begin
            state_q   <= ST_HDR;
            tx_rdy_q  <= 1'b1;
            tx_data_q <= FRAME_HEADER;
            chk_q     <= '0;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            chk_q     <= chk_nxt;
            tx_data_q <= NUM_BYTE;
            state_q   <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (xfer) begin
            chk_q     <= chk_nxt;
            idx_q     <= '0;
            word_q    <= rd_data;
            tx_data_q <= '0;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (xfer) begin
            chk_q     <= chk_nxt;
            tx_data_q <= word_q[7:0];
            state_q   <= ST_DL;
          end
        end
        ST_DL: begin
          if (xfer) begin
            chk_q     <= chk_nxt;
            tx_data_q <= word_q[15:8];
            state_q   <= ST_DH;
          end
        end
        ST_DH: begin
          if (xfer) begin
            chk_q <= chk_nxt;
            if (idx_q == LAST_IDX) begin
              tx_data_q <= chk_nxt;
              tx_eof_q  <= 1'b1;
              state_q   <= ST_CHK;
            end else begin
              // Word is latched here so later writes cannot tear the lo/hi pair.
              idx_q     <= rd_idx;
              word_q    <= rd_data;
              tx_data_q <= rd_idx;
              state_q   <= ST_ADDR;
            end
          end
        end
        ST_CHK: begin
          if (xfer) begin
            tx_eof_q <= 1'b0;
            if (pending_q || rqst_regs) begin
              // Chain straight into the next frame, keeping tx_rdy high.
              pending_q <= 1'b0;
              chk_q     <= '0;
              tx_data_q <= FRAME_HEADER;
              state_q   <= ST_HDR;
            end else begin
              tx_rdy_q  <= 1'b0;
              tx_data_q <= '0;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          tx_rdy_q <= 1'b0;
          tx_eof_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data = tx_data_q;
  assign tx_rdy  = tx_rdy_q;
  assign tx_eof  = tx_eof_q;
  assign busy    = (state_q != ST_IDLE) || pending_q;

endmodule

// File: tb/tb_registers_tx_block.sv
module tb_registers_tx_block;

  localparam int NR  = 16;
  localparam int LEN = 3 + 3 * NR;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic        rqst_regs;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_eof;
  logic        tx_ack;
  logic        busy;

  always #5 clk = ~clk;

  registers_tx_block dut (
    .clk           (clk),
    .rst           (rst),
    .register_addr (register_addr),
    .register_data (register_data),
    .register_rdy  (register_rdy),
    .rqst_regs     (rqst_regs),
    .tx_data       (tx_data),
    .tx_rdy        (tx_rdy),
    .tx_eof        (tx_eof),
    .tx_ack        (tx_ack),
    .busy          (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: byte position within the frame plus per-register snapshots.
  logic [15:0] m_shadow [NR];
  logic [15:0] m_lat    [NR];
  bit          m_active;
  bit          m_pend;
  int          m_pos;
  logic [7:0]  m_acc;

  logic [7:0]  cap [$];
  int          eof_cnt;
  int          busy_idle;

  function automatic logic [7:0] m_byte(input int p);
    int k;
    int i;
    logic [7:0] r;
    if (p == 0)            r = 8'hA5;
    else if (p == 1)       r = 8'(NR);
    else if (p == LEN - 1) r = m_acc;
    else begin
      k = p - 2;
      i = k / 3;
      case (k % 3)
        0:       r = 8'(i);
        1:       r = m_lat[i][7:0];
        default: r = m_lat[i][15:8];
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      m_active = 0;
      m_pend   = 0;
      m_pos    = 0;
      m_acc    = '0;
      for (int i = 0; i < NR; i++) m_shadow[i] = '0;
      chk("rst_tx_rdy", 32'(tx_rdy), 32'h0);
      chk("rst_tx_eof", 32'(tx_eof), 32'h0);
      chk("rst_busy",   32'(busy),   32'h0);
    end else begin
      chk("tx_rdy", 32'(tx_rdy), 32'(m_active));
      chk("busy",   32'(busy),   32'(m_active || m_pend));
      if (m_active) begin
        chk("tx_data", 32'(tx_data), 32'(m_byte(m_pos)));
        chk("tx_eof",  32'(tx_eof),  32'(m_pos == LEN - 1));
      end else begin
        chk("tx_eof_idle", 32'(tx_eof), 32'h0);
      end
      if (tx_rdy && tx_ack) begin
        cap.push_back(tx_data);
        if (tx_eof) eof_cnt++;
      end
      if (busy && !tx_rdy) busy_idle++;

      // Advance the model to what the next edge must produce.
      if (register_rdy && (int'(register_addr) < NR)) m_shadow[int'(register_addr)] = register_data;
      if (m_active && tx_ack) begin
        m_acc = m_acc ^ m_byte(m_pos);
        if (m_pos >= 1 && ((m_pos - 1) % 3 == 0) && ((m_pos - 1) / 3 < NR))
          m_lat[(m_pos - 1) / 3] = m_shadow[(m_pos - 1) / 3];
        if (m_pos == LEN - 1) begin
          if (m_pend || rqst_regs) begin
            m_pend = 0;
            m_pos  = 0;
            m_acc  = '0;
          end else begin
            m_active = 0;
          end
        end else begin
          m_pos++;
          if (rqst_regs) m_pend = 1;
        end
      end else if (rqst_regs) begin
        if (m_active) m_pend = 1;
        else begin
          m_active = 1;
          m_pos    = 0;
          m_acc    = '0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    register_addr = a;
    register_data = d;
    register_rdy  = 1'b1;
    cyc();
    register_rdy  = 1'b0;
  endtask

  task automatic dump();
    rqst_regs = 1'b1;
    cyc();
    rqst_regs = 1'b0;
    chk("latency_rdy", 32'(tx_rdy),  32'h1);
    chk("latency_hdr", 32'(tx_data), 32'hA5);
  endtask

  task automatic wait_idle(input string name, input int bound, input bit rnd);
    int n = 0;
    while ((busy || m_active) && n < bound) begin
      if (rnd) tx_ack = ($urandom_range(0, 9) < 3);
      cyc();
      n++;
    end
    tx_ack = 1'b1;
    if (n >= bound) chk({"timeout_", name}, 32'h1, 32'h0);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (m_pos != p && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) chk("timeout_pos", 32'(m_pos), 32'(p));
  endtask

  task automatic clear_cap();
    cap.delete();
    eof_cnt   = 0;
    busy_idle = 0;
  endtask

  initial begin
    rst = 1'b0;
    register_addr = '0;
    register_data = '0;
    register_rdy  = 1'b0;
    rqst_regs     = 1'b0;
    tx_ack        = 1'b1;
    cyc();
    cyc();
    chk("reset_tx_data", 32'(tx_data), 32'h0);
    chk("reset_tx_rdy",  32'(tx_rdy),  32'h0);
    chk("reset_busy",    32'(busy),    32'h0);
    rst = 1'b1;
    cyc();

    // Default frame, continuous ack.
    clear_cap();
    dump();
    wait_idle("c1", 500, 0);
    chk("c1_len",  32'(cap.size()), 32'd51);
    chk("c1_b1",   32'(cap[1]),  32'h10);
    chk("c1_b5",   32'(cap[5]),  32'h01);
    chk("c1_b6",   32'(cap[6]),  32'h00);
    chk("c1_chk",  32'(cap[50]), 32'hB5);
    chk("c1_eofs", 32'(eof_cnt), 32'd1);

    // Random ack: same bytes, hold checked every cycle against the model.
    clear_cap();
    dump();
    wait_idle("c3", 3000, 1);
    chk("c3_len", 32'(cap.size()), 32'd51);
    chk("c3_chk", 32'(cap[50]), 32'hB5);

    // In-range and out-of-range writes.
    wr(8'd3, 16'hBEEF);
    wr(8'd20, 16'h1234);
    clear_cap();
    dump();
    wait_idle("c2", 500, 0);
    chk("c2_len", 32'(cap.size()), 32'd51);
    chk("c2_idx", 32'(cap[11]), 32'h03);
    chk("c2_lo",  32'(cap[12]), 32'hEF);
    chk("c2_hi",  32'(cap[13]), 32'hBE);
    chk("c2_chk", 32'(cap[50]), 32'hE4);

    // Write reg5 on the edge its word is latched, then again during its DL byte.
    clear_cap();
    dump();
    wait_pos(16);
    wr(8'd5, 16'h1357);
    wait_pos(18);
    wr(8'd5, 16'h2468);
    wait_idle("c5a", 500, 0);
    chk("c5a_idx", 32'(cap[17]), 32'h05);
    chk("c5a_lo",  32'(cap[18]), 32'h57);
    chk("c5a_hi",  32'(cap[19]), 32'h13);
    chk("c5a_chk", 32'(cap[50]), 32'hA0);
    clear_cap();
    dump();
    wait_idle("c5b", 500, 0);
    chk("c5b_lo",  32'(cap[18]), 32'h68);
    chk("c5b_hi",  32'(cap[19]), 32'h24);
    chk("c5b_chk", 32'(cap[50]), 32'hA8);

    // Three extra requests during a frame coalesce into one follow-on frame.
    clear_cap();
    dump();
    for (int k = 0; k < 3; k++) begin
      repeat (5) cyc();
      rqst_regs = 1'b1;
      cyc();
      rqst_regs = 1'b0;
    end
    wait_idle("c4", 1000, 0);
    chk("c4_len",   32'(cap.size()), 32'd102);
    chk("c4_eofs",  32'(eof_cnt), 32'd2);
    chk("c4_gap",   32'(busy_idle), 32'd0);
    chk("c4_hdr2",  32'(cap[51]), 32'hA5);
    chk("c4_chk1",  32'(cap[50]), 32'hA8);
    chk("c4_chk2",  32'(cap[101]), 32'hA8);
    chk("c4_busy",  32'(busy), 32'h0);

    // Reset during DH of reg7 abandons the frame and restores defaults.
    clear_cap();
    dump();
    wait_pos(25);
    rst = 1'b0;
    #1;
    chk("c6_async_rdy",  32'(tx_rdy), 32'h0);
    chk("c6_async_busy", 32'(busy),   32'h0);
    chk("c6_no_eof",     32'(eof_cnt), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    clear_cap();
    dump();
    wait_idle("c6", 500, 0);
    chk("c6_len",   32'(cap.size()), 32'd51);
    chk("c6_reg3",  32'(cap[12]), 32'h00);
    chk("c6_reg5",  32'(cap[18]), 32'h00);
    chk("c6_chk",   32'(cap[50]), 32'hB5);
    chk("c6_eofs",  32'(eof_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
